// File: rtl/ex_mem_reg_pkg.sv
// Shared definitions for the EX/MEM pipeline register: access-size codes,
// trap state encoding and the bubble word loaded on flush/squash.
package ex_mem_reg_pkg;

    localparam logic [1:0] NONE = 2'b00;
    localparam logic [1:0] WORD = 2'b01;
    localparam logic [1:0] HALF = 2'b10;
    localparam logic [1:0] BYTE = 2'b11;

    localparam int DM_ADDR_W = 13;

    typedef enum logic {
        RUN  = 1'b0,
        TRAP = 1'b1
    } state_t;

    typedef struct packed {
        logic [1:0]  ls_bit;
        logic        mem_write;
        logic        ext_op;
        logic        reg_write;
        logic        mem_to_reg;
        logic [4:0]  rd;
        logic [31:0] mux5_out;
        logic [31:0] mux3_out;
    } ex_mem_t;

    localparam ex_mem_t BUBBLE = '{
        ls_bit:     NONE,
        mem_write:  1'b0,
        ext_op:     1'b0,
        reg_write:  1'b0,
        mem_to_reg: 1'b0,
        rd:         5'd0,
        mux5_out:   32'd0,
        mux3_out:   32'd0
    };

endpackage

// File: rtl/ls_align_chk.sv
// Combinational access checker: flags misaligned WORD/HALF accesses and,
// when DM_RANGE_CHK_EN is defined, accesses beyond the data memory window.
module ls_align_chk
    import ex_mem_reg_pkg::*;
(
    input  logic [1:0]  ls_bit,
    input  logic [31:0] addr,
    output logic        misaligned
`ifdef DM_RANGE_CHK_EN
    ,
    output logic        out_of_range
`endif
);

    always_comb begin
        misaligned = 1'b0;
        case (ls_bit)
            WORD:       misaligned = (addr[1:0] != 2'b00);
            HALF:       misaligned = addr[0];
            BYTE, NONE: misaligned = 1'b0;
            default:    misaligned = 1'b0;
        endcase
    end

`ifdef DM_RANGE_CHK_EN
    assign out_of_range = (ls_bit != NONE) && (addr[31:DM_ADDR_W] != '0);
`else
    // Upper address bits only matter to the range check.
    logic unused_addr_hi;
    assign unused_addr_hi = ^addr[31:2];
`endif

endmodule

// File: rtl/ex_mem_reg.sv
// EX/MEM pipeline register with stall/flush, fault squash and trap latching.
// Optional range check and exc_cause output enabled by DM_RANGE_CHK_EN.
module ex_mem_reg
    import ex_mem_reg_pkg::*;
(
    input  logic        clock,
    input  logic        reset,
    input  logic        stall,
    input  logic        flush,
    input  logic        exc_ack,
    input  logic [1:0]  ID_EX_LS_bit,
    input  logic        ID_EX_MemWrite,
    input  logic        ID_EX_Ext_op,
    input  logic        ID_EX_RegWrite,
    input  logic        ID_EX_MemtoReg,
    input  logic [4:0]  ID_EX_rd,
    input  logic [31:0] ID_EX_pc,
    input  logic [31:0] mux5_out,
    input  logic [31:0] mux3_out,
    output logic [1:0]  EX_MEM_LS_bit,
    output logic        EX_MEM_MemWrite,
    output logic        EX_MEM_Ext_op,
    output logic        EX_MEM_RegWrite,
    output logic        EX_MEM_MemtoReg,
    output logic [4:0]  EX_MEM_rd,
    output logic [31:0] EX_MEM_mux5_out,
    output logic [31:0] EX_MEM_mux3_out,
    output logic        exc_pending,
    output logic [31:0] exc_bad_addr,
    output logic [31:0] exc_pc
`ifdef DM_RANGE_CHK_EN
    ,
    output logic        exc_cause
`endif
);

    ex_mem_t     pipe_reg, pipe_next, pipe_in;
    state_t      state_reg, state_next;
    logic [31:0] bad_addr_reg, bad_addr_next;
    logic [31:0] pc_reg, pc_next;
    logic        misaligned;
    logic        fault;
    logic        cause_reg, cause_next;

    assign pipe_in = '{
        ls_bit:     ID_EX_LS_bit,
        mem_write:  ID_EX_MemWrite,
        ext_op:     ID_EX_Ext_op,
        reg_write:  ID_EX_RegWrite,
        mem_to_reg: ID_EX_MemtoReg,
        rd:         ID_EX_rd,
        mux5_out:   mux5_out,
        mux3_out:   mux3_out
    };

`ifdef DM_RANGE_CHK_EN
    logic out_of_range;

    ls_align_chk u_chk (
        .ls_bit       (ID_EX_LS_bit),
        .addr         (mux5_out),
        .misaligned   (misaligned),
        .out_of_range (out_of_range)
    );

    assign fault = misaligned | out_of_range;
`else
    ls_align_chk u_chk (
        .ls_bit     (ID_EX_LS_bit),
        .addr       (mux5_out),
        .misaligned (misaligned)
    );

    assign fault = misaligned;
`endif

    always_comb begin
        pipe_next     = pipe_reg;
        state_next    = state_reg;
        bad_addr_next = bad_addr_reg;
        pc_next       = pc_reg;
        cause_next    = cause_reg;

        // Acknowledge is honoured even while stalled or flushed.
        if (state_reg == TRAP && exc_ack) begin
            state_next = RUN;
        end

        if (flush) begin
            pipe_next = BUBBLE;
        end else if (!stall) begin
            if (state_reg == TRAP) begin
                pipe_next = BUBBLE;
            end else if (fault) begin
                pipe_next     = BUBBLE;
                bad_addr_next = mux5_out;
                pc_next       = ID_EX_pc;
                cause_next    = !misaligned;
                state_next    = TRAP;
            end else begin
                pipe_next = pipe_in;
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            pipe_reg     <= BUBBLE;
            state_reg    <= RUN;
            bad_addr_reg <= '0;
            pc_reg       <= '0;
            cause_reg    <= 1'b0;
        end else begin
            pipe_reg     <= pipe_next;
            state_reg    <= state_next;
            bad_addr_reg <= bad_addr_next;
            pc_reg       <= pc_next;
            cause_reg    <= cause_next;
        end
    end

    assign EX_MEM_LS_bit   = pipe_reg.ls_bit;
    assign EX_MEM_MemWrite = pipe_reg.mem_write;
    assign EX_MEM_Ext_op   = pipe_reg.ext_op;
    assign EX_MEM_RegWrite = pipe_reg.reg_write;
    assign EX_MEM_MemtoReg = pipe_reg.mem_to_reg;
    assign EX_MEM_rd       = pipe_reg.rd;
    assign EX_MEM_mux5_out = pipe_reg.mux5_out;
    assign EX_MEM_mux3_out = pipe_reg.mux3_out;
    assign exc_pending     = (state_reg == TRAP);
    assign exc_bad_addr    = bad_addr_reg;
    assign exc_pc          = pc_reg;

`ifdef DM_RANGE_CHK_EN
    assign exc_cause = cause_reg;
`else
    logic unused_cause;
    assign unused_cause = cause_reg;
`endif

endmodule
